// File: rtl/uart_baud_cfg_ctrl.sv
// Baud-rate change sequencer for the 16x-oversampling UART divider:
// drains in-flight frames, reprograms and resets the divider, then waits for it to toggle.
module uart_baud_cfg_ctrl #(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter logic [1:0]  RESET_RATE   = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_req,
  input  logic [1:0] cfg_rate,
  output logic       cfg_ack,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [1:0] cur_rate,
  input  logic       busy_rx,
  input  logic       busy_tx,
  output logic       link_en,
  output logic [1:0] div_rate,
  output logic       div_rst_n,
  input  logic       div_clk
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT);

  typedef enum logic [2:0] {
    BOOT_HOLD = 3'd0,
    IDLE      = 3'd1,
    DRAIN     = 3'd2,
    HOLD      = 3'd3,
    LOCK      = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                boot_q, boot_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [1:0]          req_rate_q, req_rate_d;
  logic [1:0]          div_rate_q, div_rate_d;
  logic [1:0]          cur_rate_q, cur_rate_d;
  logic                div_rst_n_q, div_rst_n_d;
  logic                link_en_q, link_en_d;
  logic                cfg_ack_q, cfg_ack_d;
  logic                cfg_done_q, cfg_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic                div_clk_q, div_clk_d;
  logic                fall_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      boot_q      <= 1'b1;
      hold_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      req_rate_q  <= RESET_RATE;
      div_rate_q  <= RESET_RATE;
      cur_rate_q  <= RESET_RATE;
      div_rst_n_q <= 1'b0;
      link_en_q   <= 1'b0;
      cfg_ack_q   <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      div_clk_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      hold_cnt_q  <= hold_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      req_rate_q  <= req_rate_d;
      div_rate_q  <= div_rate_d;
      cur_rate_q  <= cur_rate_d;
      div_rst_n_q <= div_rst_n_d;
      link_en_q   <= link_en_d;
      cfg_ack_q   <= cfg_ack_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
      div_clk_q   <= div_clk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    hold_cnt_d  = hold_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    req_rate_d  = req_rate_q;
    div_rate_d  = div_rate_q;
    cur_rate_d  = cur_rate_q;
    div_rst_n_d = div_rst_n_q;
    link_en_d   = link_en_q;
    cfg_ack_d   = 1'b0;
    cfg_done_d  = 1'b0;
    cfg_err_d   = 1'b0;
    // Sample history is pinned high outside LOCK so a bypassed divider cannot fake an edge.
    div_clk_d   = (state_q == LOCK) ? div_clk : 1'b1;
    fall_c      = div_clk_q & ~div_clk;

    case (state_q)
      BOOT_HOLD: begin
        boot_d      = 1'b1;
        hold_cnt_d  = '0;
        div_rst_n_d = 1'b0;
        link_en_d   = 1'b0;
        state_d     = HOLD;
      end
      IDLE: begin
        link_en_d   = 1'b1;
        div_rst_n_d = 1'b1;
        if (cfg_req) begin
          cfg_ack_d = 1'b1;
          if (cfg_rate != cur_rate_q) begin
            req_rate_d = cfg_rate;
            link_en_d  = 1'b0;
            state_d    = DRAIN;
          end else begin
            cfg_done_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        link_en_d = 1'b0;
        if (!busy_rx && !busy_tx) begin
          div_rate_d  = req_rate_q;
          div_rst_n_d = 1'b0;
          hold_cnt_d  = '0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        link_en_d   = 1'b0;
        div_rst_n_d = 1'b0;
        if (hold_cnt_q >= HOLD_W'(HOLD_CYCLES - 1)) begin
          div_rst_n_d = 1'b1;
          lock_cnt_d  = '0;
          state_d     = LOCK;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      LOCK: begin
        link_en_d = 1'b0;
        if (fall_c) begin
          state_d   = IDLE;
          link_en_d = 1'b1;
          boot_d    = 1'b0;
          if (!boot_q) begin
            cur_rate_d = div_rate_q;
            cfg_done_d = 1'b1;
          end
        end else if (lock_cnt_q == LOCK_W'(LOCK_TIMEOUT - 1)) begin
          // Divider never toggled: fall back to the last good rate and bring it up again.
          cfg_err_d   = 1'b1;
          div_rate_d  = cur_rate_q;
          boot_d      = 1'b1;
          div_rst_n_d = 1'b0;
          hold_cnt_d  = '0;
          state_d     = HOLD;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      default: begin
        state_d = HOLD;
        boot_d  = 1'b1;
      end
    endcase
  end

  assign cfg_ack   = cfg_ack_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign cur_rate  = cur_rate_q;
  assign link_en   = link_en_q;
  assign div_rate  = div_rate_q;
  assign div_rst_n = div_rst_n_q;

endmodule

// File: tb/tb_uart_baud_cfg_ctrl.sv
// Directed bench for uart_baud_cfg_ctrl with a behavioural 16x divider model.
module tb_uart_baud_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_req = 1'b0;
  logic [1:0] cfg_rate = 2'b00;
  logic       cfg_ack, cfg_done, cfg_err;
  logic [1:0] cur_rate;
  logic       busy_rx = 1'b0;
  logic       busy_tx = 1'b0;
  logic       link_en;
  logic [1:0] div_rate;
  logic       div_rst_n;
  logic       div_clk;

  int checks = 0;
  int errors = 0;

  // Divider model: clk_out idles high in reset, toggles every limit+1 clocks.
  logic        stuck = 1'b0;
  logic        dout = 1'b1;
  logic [10:0] dcnt = '0;
  logic [10:0] dlim;

  always_comb begin
    case (div_rate)
      2'b00:   dlim = 11'd1302;
      2'b01:   dlim = 11'd650;
      2'b10:   dlim = 11'd324;
      default: dlim = 11'd162;
    endcase
  end

  always_ff @(posedge clk) begin
    if (div_rst_n !== 1'b1) begin
      dcnt <= '0;
      dout <= 1'b1;
    end else if (dcnt == dlim) begin
      dcnt <= '0;
      dout <= ~dout;
    end else begin
      dcnt <= dcnt + 11'd1;
    end
  end

  assign div_clk = stuck ? 1'b1 : dout;

  always #5 clk = ~clk;

  uart_baud_cfg_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_req   (cfg_req),
    .cfg_rate  (cfg_rate),
    .cfg_ack   (cfg_ack),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .cur_rate  (cur_rate),
    .busy_rx   (busy_rx),
    .busy_tx   (busy_tx),
    .link_en   (link_en),
    .div_rate  (div_rate),
    .div_rst_n (div_rst_n),
    .div_clk   (div_clk)
  );

  // Counts negedges with div_rst_n low, starting with the current one.
  task automatic count_low(output int n);
    n = 0;
    while (div_rst_n === 1'b0 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_link(input int bound, output int n, output bit saw_done);
    n = 0;
    saw_done = 1'b0;
    while (link_en !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
      if (cfg_done === 1'b1) saw_done = 1'b1;
    end
  endtask

  task automatic request(input logic [1:0] rate);
    cfg_rate = rate;
    cfg_req  = 1'b1;
    @(negedge clk);
    cfg_req  = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    bit sd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (div_rst_n !== 1'b0 || link_en !== 1'b0 || div_rate !== 2'b11 || cur_rate !== 2'b11) begin
      errors++;
      $display("FAIL reset_outputs got rst_n=%b link=%b div=%b cur=%b want 0 0 11 11",
               div_rst_n, link_en, div_rate, cur_rate);
    end
    checks++;
    if ({cfg_ack, cfg_done, cfg_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses got %b want 000", {cfg_ack, cfg_done, cfg_err});
    end
    rst = 1'b0;
    count_low(n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL boot_hold_len got %0d want 4", n);
    end
    wait_link(400, n, sd);
    checks++;
    if (link_en !== 1'b1 || n < 163 || n > 170) begin
      errors++;
      $display("FAIL boot_lock got link=%b after %0d want 1 within 163..170", link_en, n);
    end
    checks++;
    if (sd || cur_rate !== 2'b11) begin
      errors++;
      $display("FAIL boot_no_done got done=%0d cur=%b want 0 11", sd, cur_rate);
    end
  endtask

  task automatic test_same_rate;
    bit bad;
    request(2'b11);
    checks++;
    if (cfg_ack !== 1'b1 || cfg_done !== 1'b1 || link_en !== 1'b1) begin
      errors++;
      $display("FAIL same_rate_pulse got ack=%b done=%b link=%b want 1 1 1", cfg_ack, cfg_done, link_en);
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (div_rst_n !== 1'b1 || link_en !== 1'b1 || div_rate !== 2'b11) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL same_rate_quiet got disturbance=1 want 0");
    end
  endtask

  task automatic test_lock_timeout;
    int n;
    bit sd;
    stuck = 1'b1;
    request(2'b10);
    checks++;
    if (cfg_ack !== 1'b1 || link_en !== 1'b0) begin
      errors++;
      $display("FAIL to_ack got ack=%b link=%b want 1 0", cfg_ack, link_en);
    end
    @(negedge clk);
    count_low(n);
    checks++;
    if (n != 4 || div_rate !== 2'b10) begin
      errors++;
      $display("FAIL to_hold got len=%0d div=%b want 4 10", n, div_rate);
    end
    n = 0;
    while (cfg_err !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 4096) begin
      errors++;
      $display("FAIL to_err_time got %0d want 4096", n);
    end
    checks++;
    if (div_rate !== 2'b11 || div_rst_n !== 1'b0 || link_en !== 1'b0) begin
      errors++;
      $display("FAIL to_revert got div=%b rst_n=%b link=%b want 11 0 0", div_rate, div_rst_n, link_en);
    end
    stuck = 1'b0;
    count_low(n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL to_rehold got %0d want 4", n);
    end
    wait_link(400, n, sd);
    checks++;
    if (link_en !== 1'b1 || cur_rate !== 2'b11 || sd) begin
      errors++;
      $display("FAIL to_relock got link=%b cur=%b done=%0d want 1 11 0", link_en, cur_rate, sd);
    end
  endtask

  task automatic test_switch_1200;
    int n;
    request(2'b00);
    checks++;
    if (cfg_ack !== 1'b1 || link_en !== 1'b0) begin
      errors++;
      $display("FAIL sw_ack got ack=%b link=%b want 1 0", cfg_ack, link_en);
    end
    @(negedge clk);
    checks++;
    if (div_rate !== 2'b00 || div_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL sw_apply got div=%b rst_n=%b want 00 0", div_rate, div_rst_n);
    end
    count_low(n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL sw_hold_len got %0d want 4", n);
    end
    n = 0;
    while (cfg_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 1303 || n > 1306) begin
      errors++;
      $display("FAIL sw_lock_time got %0d want 1303..1306", n);
    end
    checks++;
    if (cur_rate !== 2'b00 || link_en !== 1'b1) begin
      errors++;
      $display("FAIL sw_locked got cur=%b link=%b want 00 1", cur_rate, link_en);
    end
  endtask

  task automatic test_drain;
    int n;
    bit sd, bad, bad_ack;
    busy_tx = 1'b1;
    request(2'b01);
    checks++;
    if (cfg_ack !== 1'b1 || link_en !== 1'b0) begin
      errors++;
      $display("FAIL dr_ack got ack=%b link=%b want 1 0", cfg_ack, link_en);
    end
    bad = 1'b0;
    bad_ack = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cfg_req  = (i == 20);
      cfg_rate = 2'b10;
      @(negedge clk);
      if (cfg_ack === 1'b1) bad_ack = 1'b1;
      if (div_rate !== 2'b00 || div_rst_n !== 1'b1 || link_en !== 1'b0) bad = 1'b1;
    end
    cfg_req = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL dr_wait got early_change=1 want 0");
    end
    checks++;
    if (bad_ack) begin
      errors++;
      $display("FAIL dr_ignore_req got ack=1 want 0");
    end
    busy_tx = 1'b0;
    @(negedge clk);
    checks++;
    if (div_rate !== 2'b01 || div_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL dr_release got div=%b rst_n=%b want 01 0", div_rate, div_rst_n);
    end
    wait_link(1000, n, sd);
    checks++;
    if (!sd || cur_rate !== 2'b01 || link_en !== 1'b1) begin
      errors++;
      $display("FAIL dr_locked got done=%0d cur=%b link=%b want 1 01 1", sd, cur_rate, link_en);
    end
  endtask

  task automatic test_reset_mid_lock;
    int n;
    bit sd;
    request(2'b00);
    n = 0;
    while (div_rst_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    while (div_rst_n !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL ml_reach_lock got timeout after %0d want LOCK", n);
    end
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (div_rate !== 2'b11 || div_rst_n !== 1'b0 || link_en !== 1'b0 || cur_rate !== 2'b11
        || {cfg_ack, cfg_done, cfg_err} !== 3'b000) begin
      errors++;
      $display("FAIL ml_reset got div=%b rst_n=%b link=%b cur=%b pulses=%b want 11 0 0 11 000",
               div_rate, div_rst_n, link_en, cur_rate, {cfg_ack, cfg_done, cfg_err});
    end
    rst = 1'b0;
    count_low(n);
    wait_link(400, n, sd);
    checks++;
    if (link_en !== 1'b1 || cur_rate !== 2'b11 || sd) begin
      errors++;
      $display("FAIL ml_reboot got link=%b cur=%b done=%0d want 1 11 0", link_en, cur_rate, sd);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_same_rate();
    test_lock_timeout();
    test_switch_1200();
    test_drain();
    test_reset_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_cfg_ctrl.md
Name: uart_baud_cfg_ctrl

Overview:
- Sequences baud-rate changes for the UART 16x-oversampling divider (RX_div-style: `bd_rate` select, active-low divider reset, `clk_out`).
- Accepts a rate-change request and drains in-flight RX/TX frames.
- Drives the new `bd_rate`, holds the divider in reset, then confirms the divider is toggling before re-enabling the link.
- Sits between the host config register and the divider / UART RX/TX engines.

Parameters:
- HOLD_CYCLES, 4: clocks `div_rst_n` is held low during a rate switch (min 1).
- LOCK_TIMEOUT, 4096: clocks allowed in LOCK for the first `div_clk` falling edge (must exceed 1303).
- RESET_RATE, 2'b11: rate applied after reset (00=1200, 01=2400, 10=4800, 11=9600).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_req  in  1  rate-change request (level), sampled only in IDLE
- cfg_rate  in  2  requested rate, captured on acceptance
- cfg_ack  out  1  one-cycle pulse: request accepted
- cfg_done  out  1  one-cycle pulse: new rate locked
- cfg_err  out  1  one-cycle pulse: lock timeout
- cur_rate  out  2  currently locked rate
- busy_rx  in  1  RX engine mid-frame
- busy_tx  in  1  TX engine mid-frame
- link_en  out  1  RX/TX may start new frames
- div_rate  out  2  to divider `bd_rate`
- div_rst_n  out  1  to divider reset (active-low)
- div_clk  in  1  divider `clk_out` (registered, clk-synchronous)

Behaviour:
- **States:** BOOT_HOLD, IDLE, DRAIN, HOLD, LOCK. HOLD/LOCK are shared by boot and switch; a `boot` flag distinguishes them.
- **Reset** (`rst`=1, overrides everything):
  - State=HOLD with boot=1, hold counter=0.
  - `div_rate`=`cur_rate`=RESET_RATE; `div_rst_n`=0; `link_en`=0.
  - `cfg_ack`=`cfg_done`=`cfg_err`=0.
  - `div_clk` sample register=1.
- **IDLE:** `link_en`=1, `div_rst_n`=1.
  - `cfg_req`=1 and `cfg_rate`!=`cur_rate`: capture the rate; next cycle `cfg_ack`=1, `link_en`=0, state=DRAIN.
  - `cfg_req`=1 and `cfg_rate`==`cur_rate`: next cycle `cfg_ack`=1 and `cfg_done`=1 together; stay IDLE; divider untouched; `link_en` stays 1.
- **DRAIN:** `link_en`=0. When `busy_rx`=0 and `busy_tx`=0 in the same cycle:
  - `div_rate`<=captured rate, `div_rst_n`<=0, state=HOLD.
  - No timeout; waits indefinitely.
- **HOLD:** `div_rst_n`=0 for exactly HOLD_CYCLES clocks, then `div_rst_n`<=1, LOCK counter cleared, state=LOCK.
  - `div_clk` is ignored while `div_rst_n`=0, because the divider bypasses to `clk`.
- **LOCK:**
  - Register `div_clk` each cycle; edge = prev 1 and current 0.
  - On the first falling edge, state=IDLE and `link_en`=1. If boot=0, also `cur_rate`<=`div_rate` and `cfg_done`=1 for one cycle. Clear boot.
  - If the counter reaches LOCK_TIMEOUT-1 without an edge:
    - Pulse `cfg_err` for one cycle.
    - Set `div_rate`<=`cur_rate` (revert to the old rate) and boot=1.
    - Enter HOLD (re-bring-up; `link_en` stays 0). Repeats on every timeout.
- **Request handling:** `cfg_req` outside IDLE is ignored (no `cfg_ack`); the requester holds or re-asserts. A request held continuously across DONE is re-evaluated in IDLE, so the same-rate rule prevents retriggering.
- **Counters:** hold counter width $clog2(HOLD_CYCLES+1); lock counter width $clog2(LOCK_TIMEOUT); neither wraps (saturate/terminate at the compare).
- **Timing:** expected lock time after `div_rst_n` rises is divider limit+1 clocks, plus 1–2 sample cycles.
- **Mid-operation reset:** `rst` asserted in any state returns to reset values. `cur_rate` reverts to RESET_RATE and any pending request is lost.

Test Plan:
- Reset 3 cycles, `div_clk` model at 9600 (toggle every 163) -> `div_rst_n` low 4 cycles, `link_en`=1 within ~170 cycles, `cur_rate`=11, no `cfg_done`.
- From IDLE at 9600, `cfg_req`=1 `cfg_rate`=00, busy low -> `cfg_ack` next cycle; `div_rate`=00 and `div_rst_n`=0 for 4 cycles; `cfg_done` ~1303–1306 cycles after release; `cur_rate`=00; `link_en`=1.
- `cfg_req` with `cfg_rate`=`cur_rate`=11 -> `cfg_ack` and `cfg_done` in the same cycle; `div_rst_n` never drops; `link_en` stays 1.
- Request to 01 with `busy_tx`=1 for 50 cycles -> `link_en`=0 immediately, `div_rate` unchanged until `busy_tx` falls, then HOLD; second `cfg_req` pulse during DRAIN gets no `cfg_ack`.
- Request to 10 with `div_clk` stuck high -> `cfg_err` at 4096 cycles into LOCK; `div_rate` reverts to 11; re-HOLD; lock at 9600; `cur_rate`=11; no `cfg_done`.
- `rst` asserted mid-LOCK of a 1200 switch -> next cycle `div_rate`=11, `div_rst_n`=0, `link_en`=0, all pulses low.
